// File: rtl/button_event.sv
// Turns the clean debounced button level into single-cycle UI events
// (press, release, short click, long press, auto-repeat) plus a held level and press counter.
module button_event #(
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 200,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       db,
  output logic       press_p,
  output logic       rel_p,
  output logic       short_p,
  output logic       long_p,
  output logic       rpt_p,
  output logic       held,
  output logic [7:0] press_cnt,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_e;

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_TC  = CNT_W'(REPEAT_CYCLES - 1);

  if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) > CNT_MAX) begin : g_bad_long
    $error("button_event: LONG_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) > CNT_MAX) begin : g_bad_rpt
    $error("button_event: REPEAT_CYCLES out of range");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       press_cnt_q, press_cnt_d;
  logic             press_p_q, press_p_d;
  logic             rel_p_q, rel_p_d;
  logic             short_p_q, short_p_d;
  logic             long_p_q, long_p_d;
  logic             rpt_p_q, rpt_p_d;
  logic             held_q, held_d;

  // Release is checked before the terminal count so it wins on a coincident edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_cnt_d = press_cnt_q;
    press_p_d   = 1'b0;
    rel_p_d     = 1'b0;
    short_p_d   = 1'b0;
    long_p_d    = 1'b0;
    rpt_p_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (db) begin
          state_d     = ST_PRESSED;
          cnt_d       = '0;
          press_p_d   = 1'b1;
          press_cnt_d = press_cnt_q + 8'd1;
        end
      end
      ST_PRESSED: begin
        if (!db) begin
          state_d   = ST_IDLE;
          rel_p_d   = 1'b1;
          short_p_d = 1'b1;
        end else if (cnt_q == LONG_TC) begin
          state_d  = ST_LONG;
          cnt_d    = '0;
          long_p_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LONG: begin
        if (!db) begin
          state_d = ST_IDLE;
          rel_p_d = 1'b1;
        end else if (cnt_q == RPT_TC) begin
          cnt_d   = '0;
          rpt_p_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      press_cnt_q <= '0;
      press_p_q   <= 1'b0;
      rel_p_q     <= 1'b0;
      short_p_q   <= 1'b0;
      long_p_q    <= 1'b0;
      rpt_p_q     <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_cnt_q <= press_cnt_d;
      press_p_q   <= press_p_d;
      rel_p_q     <= rel_p_d;
      short_p_q   <= short_p_d;
      long_p_q    <= long_p_d;
      rpt_p_q     <= rpt_p_d;
      held_q      <= held_d;
    end
  end

  assign press_p   = press_p_q;
  assign rel_p     = rel_p_q;
  assign short_p   = short_p_q;
  assign long_p    = long_p_q;
  assign rpt_p     = rpt_p_q;
  assign held      = held_q;
  assign press_cnt = press_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: directed and random db patterns against a press-length model,
// with expected output vectors queued per edge and compared by an independent monitor.
module tb_button_event;

  localparam int unsigned LONG_C = 8;
  localparam int unsigned RPT_C  = 4;
  localparam int W = 14;  // {press, rel, short, long, rpt, held, press_cnt[7:0]}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       db = 1'b0;
  logic       press_p, rel_p, short_p, long_p, rpt_p, held;
  logic [7:0] press_cnt;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // model state
  bit pressed = 0;
  int hold_edges = 0;
  int m_cnt = 0;
  int m_press_n = 0;
  int m_rel_n = 0;
  int seen_press_n = 0;
  int seen_rel_n = 0;

  button_event #(.LONG_CYCLES(LONG_C), .REPEAT_CYCLES(RPT_C), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .db(db),
    .press_p(press_p), .rel_p(rel_p), .short_p(short_p), .long_p(long_p),
    .rpt_p(rpt_p), .held(held), .press_cnt(press_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Expected response for one edge, from press-length arithmetic:
  // edge j after the press edge fires long at j==LONG, repeat at LONG+k*RPT,
  // and a release at j<=LONG is a short click.
  task automatic model_edge(input logic d, input logic r);
    logic e_press, e_rel, e_short, e_long, e_rpt;
    e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_rpt = 0;
    if (!r) begin
      pressed = 0; hold_edges = 0; m_cnt = 0;
    end else if (!pressed) begin
      if (d) begin
        pressed = 1; hold_edges = 0; m_cnt = (m_cnt + 1) % 256;
        e_press = 1; m_press_n++;
      end
    end else if (!d) begin
      pressed = 0; e_rel = 1; m_rel_n++;
      e_short = (hold_edges + 1 <= int'(LONG_C));
    end else begin
      hold_edges++;
      if (hold_edges == int'(LONG_C)) e_long = 1;
      else if (hold_edges > int'(LONG_C) && (hold_edges - int'(LONG_C)) % int'(RPT_C) == 0) e_rpt = 1;
    end
    exp_q.push_back({e_press, e_rel, e_short, e_long, e_rpt, logic'(pressed), 8'(m_cnt)});
  endtask

  task automatic step(input logic d, input logic r);
    db = d;
    rst_n = r;
    @(posedge clk);
    model_edge(d, r);
    @(negedge clk);
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b1);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output vector; pop and compare.
  always @(negedge clk) begin
    logic [W-1:0] act, exp_v;
    act = {press_p, rel_p, short_p, long_p, rpt_p, held, press_cnt};
    if (press_p) seen_press_n++;
    if (rel_p) seen_rel_n++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL outputs @%0t: got p%b r%b s%b l%b rp%b h%b cnt=%0d, expected p%b r%b s%b l%b rp%b h%b cnt=%0d",
                 $time, act[13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                 exp_v[13], exp_v[12], exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
      checks++;
      if (!$onehot0({press_p, rel_p, long_p, rpt_p}) || (short_p && !rel_p)) begin
        errors++;
        $display("FAIL exclusivity @%0t: got p%b r%b s%b l%b rp%b, expected at most one pulse",
                 $time, press_p, rel_p, short_p, long_p, rpt_p);
      end
    end
  end

  initial begin
    int len;
    db = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    step(1'b0, 1'b0);

    hold(1'b0, 20);                       // idle after reset
    hold(1'b1, 3);  hold(1'b0, 3);        // short click
    hold(1'b1, 17); hold(1'b0, 3);        // long press with two repeats
    hold(1'b1, 8);  hold(1'b0, 3);        // release on the long terminal edge
    hold(1'b1, 7);  hold(1'b0, 2);        // release one edge before terminal
    hold(1'b1, 9);  hold(1'b0, 2);        // release right after long
    hold(1'b1, 1);  hold(1'b0, 1);        // minimum press
    hold(1'b1, 1);  hold(1'b0, 1);        // back-to-back

    hold(1'b1, 12);                       // reset while in LONG, db stays high
    step(1'b1, 1'b0);
    hold(1'b1, 3);
    hold(1'b0, 2);

    step(1'b1, 1'b0);                     // clear counter, then wrap it
    step(1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
    end
    step(1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin    // random presses and gaps
      len = $urandom_range(1, 22);
      hold(1'b1, len);
      hold(1'b0, $urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) step(1'(($urandom_range(0, 1))), 1'b0);
    end
    hold(1'b0, 2);

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("press_pulse_count", seen_press_n, m_press_n);
    check("rel_pulse_count", seen_rel_n, m_rel_n);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event.md
# button_event

Downstream consumer of the switch debouncer: takes the clean, synchronous debounced level `db` and turns it into single-cycle user-interface events. It emits press, release, short-click, long-press and auto-repeat pulses, plus a held level and a wrapping press counter. It sits between the debouncer and the control logic that reacts to buttons, so that logic never inspects raw levels or times presses itself.

## Interface
- `LONG_CYCLES`, default 1000: cycles `db` must stay high after the press is recognised before `long_p` fires; legal range 2..2**CNT_W-1.
- `REPEAT_CYCLES`, default 200: period of `rpt_p` while the button remains held after `long_p`; legal range 1..2**CNT_W-1.
- `CNT_W`, default 16: width of the internal hold counter.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `db` input 1: debounced switch level from the debouncer, already synchronous to `clk`; 1 = pressed.
- `press_p` output 1: one-cycle pulse on press recognition.
- `rel_p` output 1: one-cycle pulse on release.
- `short_p` output 1: one-cycle pulse on a release that happens before `long_p`; coincides with `rel_p`.
- `long_p` output 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `rpt_p` output 1: one-cycle pulse every `REPEAT_CYCLES` while held after `long_p`.
- `held` output 1: level, high while in PRESSED or LONG.
- `press_cnt` output 8: count of recognised presses; wraps 255→0.

## Operation
- FSM states:
  - IDLE: button up.
  - PRESSED: button down, long threshold not reached.
  - LONG: long press reached, auto-repeat running.
- Hold counter `cnt` is CNT_W bits. Every output is registered.
- IDLE:
  - `db`=1 → PRESSED; `cnt`←0; `press_p`=1; `press_cnt`←`press_cnt`+1 (mod 256).
  - `db`=0 → stay in IDLE.
- PRESSED:
  - `db`=0 → IDLE; `rel_p`=1; `short_p`=1.
  - `db`=1 and `cnt`==LONG_CYCLES-1 → LONG; `cnt`←0; `long_p`=1.
  - Otherwise `cnt`←`cnt`+1.
- LONG:
  - `db`=0 → IDLE; `rel_p`=1; `short_p`=0.
  - `db`=1 and `cnt`==REPEAT_CYCLES-1 → `rpt_p`=1; `cnt`←0.
  - Otherwise `cnt`←`cnt`+1.
- Release has priority over a terminal count reached at the same edge: that edge emits `rel_p` (and `short_p` if in PRESSED), never `long_p` or `rpt_p`.
- `cnt` never exceeds its terminal value, so no counter overflow is possible for legal parameters.
- Pulse exclusivity:
  - At most one of `press_p`, `long_p`, `rpt_p`, `rel_p` is high in any cycle.
  - `short_p` only ever coincides with `rel_p`.
- Illegal parameter values are out of scope and rejected by an elaboration-time assertion.

## Timing
- Reset: at a rising edge with `rst_n`=0:
  - State ← IDLE; `cnt`←0; `press_cnt`←0.
  - All pulse outputs and `held` ← 0.
  - This takes effect regardless of state; a press in progress produces no `rel_p`.
- Post-reset: if `db` is already 1 at the first edge with `rst_n`=1, that edge is a press and produces `press_p`.
- Let e0 be the first edge at which IDLE samples `db`=1:
  - `press_p` and `held` are high in the cycle after e0 (1-cycle latency).
  - `long_p` is high after edge e0+LONG_CYCLES, provided `db`=1 at every edge up to and including it.
  - `rpt_p` is high after edge e0+LONG_CYCLES+k·REPEAT_CYCLES, k≥1.
- Release: for the first edge eR sampling `db`=0 in PRESSED or LONG:
  - `rel_p` (and `short_p` if applicable) is high in the cycle after eR.
  - `held` drops in that same cycle.
- Minimum press (`db` high at exactly one edge): `press_p` in cycle 1, `rel_p` and `short_p` in cycle 2.
- Back-to-back: IDLE re-accepts a press at the edge after the release edge; no dead cycle beyond the state change.

## Test plan
Bench parameters: LONG_CYCLES=8, REPEAT_CYCLES=4.
- Reset then `db`=0 for 20 cycles → all outputs stay 0, `press_cnt`=0.
- `db` high for 3 edges then low → `press_p` once; 3 cycles later `rel_p`=`short_p`=1; no `long_p`; `press_cnt`=1; `held` high for exactly 3 cycles.
- `db` high for 17 edges → `press_p` after e0, `long_p` after e0+8, `rpt_p` after e0+12 and e0+16, then `rel_p` with `short_p`=0.
- `db` high for exactly 8 edges (release edge coincides with the long terminal) → `rel_p`+`short_p`, no `long_p`.
- Hold `db`=1 in LONG and assert `rst_n`=0 for one edge → all outputs 0, no `rel_p`; with `db` still 1 after reset, next edge gives `press_p` and `press_cnt`=1.
- 256 minimum-length presses → `press_cnt` wraps to 0, and exactly 256 `press_p` and 256 `rel_p` pulses are counted.
